// File: rtl/rv_dmem_arb_if.sv
// D_MEM arbiter request type and bus bundle shared by the arbiter,
// the core MA stage, the external requester and D_MEM.
package rv_dmem_pkg;
    typedef struct packed {
        logic        wr_en;
        logic        rd_en;
        logic [31:0] address;
        logic [31:0] wr_data;
        logic [3:0]  byte_en;
        logic        is_signed;
    } t_core2mem_req;
endpackage

interface rv_dmem_arb_if;
    import rv_dmem_pkg::*;

    t_core2mem_req core2dmem_req_Q103H;
    logic          core_ready_Q103H;
    logic          ext_req_valid;
    t_core2mem_req ext_req;
    logic          ext_req_ready;
    logic          ext_rsp_valid;
    logic [31:0]   ext_rd_data;
    t_core2mem_req arb2dmem_req;
    logic [31:0]   dmem_rd_data;

    modport slave (
        input  core2dmem_req_Q103H,
        input  ext_req_valid,
        input  ext_req,
        input  dmem_rd_data,
        output core_ready_Q103H,
        output ext_req_ready,
        output ext_rsp_valid,
        output ext_rd_data,
        output arb2dmem_req
    );

    modport master (
        output core2dmem_req_Q103H,
        output ext_req_valid,
        output ext_req,
        output dmem_rd_data,
        input  core_ready_Q103H,
        input  ext_req_ready,
        input  ext_rsp_valid,
        input  ext_rd_data,
        input  arb2dmem_req
    );
endinterface

// File: rtl/rv_dmem_arb.sv
// Single-port D_MEM arbiter between core MA stage and an external requester.
// Define DMEM_ARB_RR_EN for round-robin on contention instead of core priority.
module rv_dmem_arb
    import rv_dmem_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic         clk,
    input  logic         rst,
    rv_dmem_arb_if.slave bus
);

    logic              core_req;
    logic              ext_act;
    logic              both;
    logic              core_wins;
    logic              core_grant;
    logic              ext_grant;
    logic              rd_grant;
    logic              streak_hit;
    logic [3:0]        streak_cnt;
    logic [RD_LAT-1:0] trk_valid;
    logic [RD_LAT-1:0] trk_owner;
    logic              rsp;
    t_core2mem_req     arb_req;

    assign core_req   = bus.core2dmem_req_Q103H.wr_en
                      | bus.core2dmem_req_Q103H.rd_en;
    assign ext_act    = bus.ext_req_valid
                      & (bus.ext_req.wr_en | bus.ext_req.rd_en);
    assign both       = core_req & ext_act;
    assign streak_hit = (streak_cnt == 4'(MAX_STREAK));

`ifdef DMEM_ARB_RR_EN
    logic last_winner;

    // last_winner = 1 means ext won the previous contended cycle
    assign core_wins = last_winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= 1'b1;
        end else if (both) begin
            last_winner <= ext_grant;
        end
    end
`else
    assign core_wins = ~streak_hit;
`endif

    always_comb begin
        core_grant = 1'b0;
        ext_grant  = 1'b0;
        if (!rst) begin
            if (both) begin
                core_grant = core_wins;
                ext_grant  = ~core_wins;
            end else begin
                core_grant = core_req;
                ext_grant  = ext_act;
            end
        end
    end

    always_comb begin
        arb_req = '0;
        if (core_grant) begin
            arb_req = bus.core2dmem_req_Q103H;
        end else if (ext_grant) begin
            arb_req = bus.ext_req;
        end
    end

    assign rd_grant = arb_req.rd_en;

    assign bus.arb2dmem_req     = arb_req;
    assign bus.core_ready_Q103H = rst | ~core_req | core_grant;
    assign bus.ext_req_ready    = ext_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_cnt <= 4'd0;
        end else if (ext_grant || !ext_act) begin
            streak_cnt <= 4'd0;
        end else if (core_grant && !streak_hit) begin
            streak_cnt <= streak_cnt + 4'd1;
        end
    end

    // Read tracking: owner bit 1 marks an ext read
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            trk_owner <= '0;
        end else begin
            trk_valid[0] <= rd_grant;
            trk_owner[0] <= ext_grant;
            for (int i = 1; i < RD_LAT; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_owner[i] <= trk_owner[i-1];
            end
        end
    end

    assign rsp = ~rst & trk_valid[RD_LAT-1] & trk_owner[RD_LAT-1];

    assign bus.ext_rsp_valid = rsp;
    assign bus.ext_rd_data   = rsp ? bus.dmem_rd_data : 32'd0;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Bench for rv_dmem_arb: three instances (RD_LAT 1..3) share stimulus and
// are compared against a cycle-level reference model with a D_MEM model.
module tb_rv_dmem_arb;
    import rv_dmem_pkg::*;

    localparam int MS = 4;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    t_core2mem_req core_in;
    t_core2mem_req ext_in;
    logic          ext_vld;
    logic [31:0]   rdd [NI];

    rv_dmem_arb_if b1();
    rv_dmem_arb_if b2();
    rv_dmem_arb_if b3();

    assign b1.core2dmem_req_Q103H = core_in;
    assign b1.ext_req_valid       = ext_vld;
    assign b1.ext_req             = ext_in;
    assign b1.dmem_rd_data        = rdd[0];
    assign b2.core2dmem_req_Q103H = core_in;
    assign b2.ext_req_valid       = ext_vld;
    assign b2.ext_req             = ext_in;
    assign b2.dmem_rd_data        = rdd[1];
    assign b3.core2dmem_req_Q103H = core_in;
    assign b3.ext_req_valid       = ext_vld;
    assign b3.ext_req             = ext_in;
    assign b3.dmem_rd_data        = rdd[2];

    logic [NI-1:0] o_cr, o_er, o_rv;
    logic [31:0]   o_rd [NI];
    t_core2mem_req o_arb [NI];

    assign o_cr[0] = b1.core_ready_Q103H;
    assign o_er[0] = b1.ext_req_ready;
    assign o_rv[0] = b1.ext_rsp_valid;
    assign o_rd[0] = b1.ext_rd_data;
    assign o_arb[0] = b1.arb2dmem_req;
    assign o_cr[1] = b2.core_ready_Q103H;
    assign o_er[1] = b2.ext_req_ready;
    assign o_rv[1] = b2.ext_rsp_valid;
    assign o_rd[1] = b2.ext_rd_data;
    assign o_arb[1] = b2.arb2dmem_req;
    assign o_cr[2] = b3.core_ready_Q103H;
    assign o_er[2] = b3.ext_req_ready;
    assign o_rv[2] = b3.ext_rsp_valid;
    assign o_rd[2] = b3.ext_rd_data;
    assign o_arb[2] = b3.arb2dmem_req;

    rv_dmem_arb #(.RD_LAT(1), .MAX_STREAK(MS)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    rv_dmem_arb #(.RD_LAT(2), .MAX_STREAK(MS)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave));
    rv_dmem_arb #(.RD_LAT(3), .MAX_STREAK(MS)) u_dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave));

    // Reference model state
    int            lat [NI] = '{1, 2, 3};
    logic [31:0]   mem [256];
    logic          due_v [NI][8];
    logic [31:0]   due_d [NI][8];
    int            streak;
    logic          last_ext;
    int            cyc;
    logic          c_stall;

    logic          x_cr, x_er, x_cg, x_eg;
    t_core2mem_req x_arb;
    logic          x_rv [NI];
    logic [31:0]   x_rd [NI];

    logic          s_cr [NI];
    logic          s_er [NI];
    logic          s_rv [NI];
    logic [31:0]   s_rd [NI];
    t_core2mem_req s_arb [NI];

    int n_chk = 0;
    int n_err = 0;

    function automatic t_core2mem_req mk(logic wr, logic rd,
            logic [31:0] a, logic [31:0] d, logic [3:0] be);
        t_core2mem_req r;
        r.wr_en     = wr;
        r.rd_en     = rd;
        r.address   = a;
        r.wr_data   = d;
        r.byte_en   = be;
        r.is_signed = 1'b0;
        return r;
    endfunction

    task automatic idle();
        core_in = '0;
        ext_vld = 1'b0;
        ext_in  = '0;
    endtask

    // One clock cycle: drive D_MEM data, compute expectations, sample, advance.
    task automatic tick();
        int sl;
        logic creq, eact;
        logic [7:0] wi;
        sl = cyc % 8;
        for (int k = 0; k < NI; k++)
            rdd[k] = due_v[k][sl] ? due_d[k][sl] : $urandom();
        #1;
        creq = core_in.wr_en | core_in.rd_en;
        eact = ext_vld & (ext_in.wr_en | ext_in.rd_en);
        x_cg = 1'b0;
        x_eg = 1'b0;
        if (!rst) begin
            if (creq && eact) begin
`ifdef DMEM_ARB_RR_EN
                x_cg = last_ext;
`else
                x_cg = (streak != MS);
`endif
                x_eg = !x_cg;
            end else begin
                x_cg = creq;
                x_eg = eact;
            end
        end
        if (x_cg) x_arb = core_in;
        else if (x_eg) x_arb = ext_in;
        else x_arb = '0;
        x_cr = rst || !creq || x_cg;
        x_er = x_eg;
        c_stall = !x_cr;
        for (int k = 0; k < NI; k++) begin
            x_rv[k] = !rst && due_v[k][sl];
            x_rd[k] = x_rv[k] ? due_d[k][sl] : 32'd0;
            s_cr[k]  = o_cr[k];
            s_er[k]  = o_er[k];
            s_rv[k]  = o_rv[k];
            s_rd[k]  = o_rd[k];
            s_arb[k] = o_arb[k];
            due_v[k][sl] = 1'b0;
        end
        if (rst) begin
            streak   = 0;
            last_ext = 1'b1;
            for (int k = 0; k < NI; k++)
                for (int j = 0; j < 8; j++) due_v[k][j] = 1'b0;
        end else begin
            wi = x_arb.address[9:2];
            if (x_arb.rd_en) begin
                for (int k = 0; k < NI; k++) begin
                    due_v[k][(cyc + lat[k]) % 8] = x_eg;
                    due_d[k][(cyc + lat[k]) % 8] = mem[wi];
                end
            end
            if (x_arb.wr_en)
                for (int b = 0; b < 4; b++)
                    if (x_arb.byte_en[b])
                        mem[wi][8*b +: 8] = x_arb.wr_data[8*b +: 8];
            if (x_eg || !eact) streak = 0;
            else if (x_cg && streak < MS) streak++;
            if (creq && eact) last_ext = x_eg;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_in = mk(1'b0, 1'b1, 32'h100, 32'd0, 4'hF);
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h40, 32'd0, 4'hF);
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++; if (s_cr[k] !== 1'b1) begin n_err++; $display("FAIL reset_core_ready inst%0d got %b want 1", k, s_cr[k]); end
            n_chk++; if (s_er[k] !== 1'b0) begin n_err++; $display("FAIL reset_ext_ready inst%0d got %b want 0", k, s_er[k]); end
            n_chk++; if ((s_arb[k].rd_en | s_arb[k].wr_en) !== 1'b0) begin n_err++; $display("FAIL reset_mem_en inst%0d got rd%b wr%b want 0", k, s_arb[k].rd_en, s_arb[k].wr_en); end
            n_chk++; if (s_rv[k] !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid inst%0d got %b want 0", k, s_rv[k]); end
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_core_only();
        idle();
        tick();
        core_in = mk(1'b0, 1'b1, 32'h100, 32'd0, 4'hF);
        tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++; if (s_cr[k] !== 1'b1) begin n_err++; $display("FAIL core_only_ready inst%0d got %b want 1", k, s_cr[k]); end
            n_chk++; if (s_arb[k].rd_en !== 1'b1 || s_arb[k].address !== 32'h100) begin n_err++; $display("FAIL core_only_req inst%0d got rd%b addr %h want rd1 addr 100", k, s_arb[k].rd_en, s_arb[k].address); end
        end
        core_in = '0;
        for (int t = 0; t < 4; t++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk++; if (s_arb[k].rd_en !== 1'b0 || s_cr[k] !== 1'b1) begin n_err++; $display("FAIL core_only_after inst%0d got rd%b rdy%b want rd0 rdy1", k, s_arb[k].rd_en, s_cr[k]); end
                n_chk++; if (s_rv[k] !== 1'b0) begin n_err++; $display("FAIL core_only_rsp inst%0d got %b want 0", k, s_rv[k]); end
            end
        end
    endtask

    task automatic test_ext_read();
        logic e;
        idle();
        tick();
        mem[8'h10] = 32'hDEADBEEF;
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h40, 32'd0, 4'hF);
        tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++; if (s_er[k] !== 1'b1) begin n_err++; $display("FAIL ext_read_grant inst%0d got %b want 1", k, s_er[k]); end
        end
        idle();
        for (int t = 1; t <= 4; t++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                e = (lat[k] == t);
                n_chk++; if (s_rv[k] !== e) begin n_err++; $display("FAIL ext_read_valid inst%0d cyc+%0d got %b want %b", k, t, s_rv[k], e); end
                n_chk++; if (s_rd[k] !== (e ? 32'hDEADBEEF : 32'd0)) begin n_err++; $display("FAIL ext_read_data inst%0d cyc+%0d got %h want %h", k, t, s_rd[k], e ? 32'hDEADBEEF : 32'd0); end
            end
        end
    endtask

    task automatic test_streak();
        logic ec [6];
        logic [31:0] a;
        ec = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        idle();
        tick();
        a = 32'h200;
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h80, 32'd0, 4'hF);
        core_in = mk(1'b0, 1'b1, a, 32'd0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk++; if (s_cr[k] !== ec[i]) begin n_err++; $display("FAIL streak_core_ready inst%0d cycle%0d got %b want %b", k, i, s_cr[k], ec[i]); end
                n_chk++; if (s_er[k] !== !ec[i]) begin n_err++; $display("FAIL streak_ext_ready inst%0d cycle%0d got %b want %b", k, i, s_er[k], !ec[i]); end
            end
            if (ec[i]) begin
                a = a + 32'd4;
                core_in = mk(1'b0, 1'b1, a, 32'd0, 4'hF);
            end
        end
        idle();
        for (int t = 0; t < 4; t++) tick();
    endtask

    task automatic test_store_ext();
        logic [31:0] wd;
        idle();
        tick();
        wd = $urandom();
        core_in = mk(1'b1, 1'b0, 32'h20, wd, 4'b0101);
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h44, 32'd0, 4'hF);
        tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++; if (s_arb[k].wr_en !== 1'b1 || s_arb[k].wr_data !== wd || s_arb[k].byte_en !== 4'b0101) begin n_err++; $display("FAIL store_req inst%0d got wr%b d%h be%b want wr1 d%h be0101", k, s_arb[k].wr_en, s_arb[k].wr_data, s_arb[k].byte_en, wd); end
            n_chk++; if (s_er[k] !== 1'b0) begin n_err++; $display("FAIL store_ext_ready inst%0d got %b want 0", k, s_er[k]); end
        end
        core_in = '0;
        tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++; if (s_er[k] !== 1'b1 || s_arb[k].rd_en !== 1'b1 || s_arb[k].address !== 32'h44) begin n_err++; $display("FAIL store_ext_next inst%0d got rdy%b rd%b a%h want rdy1 rd1 a44", k, s_er[k], s_arb[k].rd_en, s_arb[k].address); end
        end
        idle();
        for (int t = 0; t < 4; t++) tick();
    endtask

    task automatic test_reset_mid();
        logic e;
        idle();
        tick();
        mem[8'h0C] = 32'h12345678;
        mem[8'h0D] = 32'hCAFEF00D;
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h30, 32'd0, 4'hF);
        tick();
        idle();
        rst = 1'b1;
        tick();
        for (int k = 0; k < NI; k++) begin
            n_chk++; if (s_rv[k] !== 1'b0 || s_cr[k] !== 1'b1 || s_er[k] !== 1'b0) begin n_err++; $display("FAIL rst_mid_out inst%0d got rv%b cr%b er%b want 0 1 0", k, s_rv[k], s_cr[k], s_er[k]); end
        end
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk++; if (s_rv[k] !== 1'b0) begin n_err++; $display("FAIL rst_mid_drop inst%0d got %b want 0", k, s_rv[k]); end
            end
        end
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h34, 32'd0, 4'hF);
        tick();
        idle();
        for (int t = 1; t <= 3; t++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                e = (lat[k] == t);
                n_chk++; if (s_rv[k] !== e || s_rd[k] !== (e ? 32'hCAFEF00D : 32'd0)) begin n_err++; $display("FAIL rst_mid_fresh inst%0d cyc+%0d got %b %h want %b", k, t, s_rv[k], s_rd[k], e); end
            end
        end
    endtask

`ifdef DMEM_ARB_RR_EN
    task automatic test_rr();
        logic e;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        core_in = mk(1'b0, 1'b1, 32'h100, 32'd0, 4'hF);
        ext_vld = 1'b1;
        ext_in  = mk(1'b0, 1'b1, 32'h104, 32'd0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            tick();
            e = (i % 2 == 0);
            for (int k = 0; k < NI; k++) begin
                n_chk++; if (s_cr[k] !== e || s_er[k] !== !e) begin n_err++; $display("FAIL rr_alt inst%0d cycle%0d got cr%b er%b want cr%b", k, i, s_cr[k], s_er[k], e); end
            end
        end
        idle();
        for (int t = 0; t < 4; t++) tick();
    endtask
`endif

    task automatic test_random();
        int r;
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!c_stall) begin
                r = $urandom_range(0, 3);
                if (r == 0) core_in = '0;
                else core_in = mk(r == 2, r != 2, 32'($urandom_range(0, 63)) << 2, $urandom(), 4'($urandom_range(1, 15)));
                core_in.is_signed = 1'($urandom());
            end
            ext_vld = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 4);
            if (r == 0) ext_in = mk(1'b0, 1'b0, $urandom(), $urandom(), 4'hF);
            else ext_in = mk(r > 2, r <= 2, 32'($urandom_range(0, 63)) << 2, $urandom(), 4'($urandom_range(1, 15)));
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk++; if (s_cr[k] !== x_cr) begin n_err++; $display("FAIL rnd_core_ready inst%0d cyc%0d got %b want %b", k, cyc, s_cr[k], x_cr); end
                n_chk++; if (s_er[k] !== x_er) begin n_err++; $display("FAIL rnd_ext_ready inst%0d cyc%0d got %b want %b", k, cyc, s_er[k], x_er); end
                n_chk++; if (s_arb[k] !== x_arb) begin n_err++; $display("FAIL rnd_mem_req inst%0d cyc%0d got %h want %h", k, cyc, s_arb[k], x_arb); end
                n_chk++; if (s_rv[k] !== x_rv[k] || s_rd[k] !== x_rd[k]) begin n_err++; $display("FAIL rnd_rsp inst%0d cyc%0d got %b %h want %b %h", k, cyc, s_rv[k], s_rd[k], x_rv[k], x_rd[k]); end
            end
        end
        rst = 1'b0;
        idle();
        for (int t = 0; t < 4; t++) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        for (int k = 0; k < NI; k++)
            for (int j = 0; j < 8; j++) begin
                due_v[k][j] = 1'b0;
                due_d[k][j] = 32'd0;
            end
        for (int k = 0; k < NI; k++) rdd[k] = 32'd0;
        streak   = 0;
        last_ext = 1'b1;
        cyc      = 0;
        c_stall  = 1'b0;
        rst      = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
`ifdef DMEM_ARB_RR_EN
        test_rr();
`endif
        test_core_only();
        test_ext_read();
`ifndef DMEM_ARB_RR_EN
        test_streak();
        test_store_ext();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
